i2s_trnmtr_ctrl: RTL and testbench

I2S_TRNMTR_CTRL -- requirements
Module: i2s_trnmtr_ctrl

---
 rtl/i2s_pkg.sv | 14 +
 rtl/i2s_sck_gen.sv | 49 ++++
 rtl/i2s_trnmtr_ctrl.sv | 164 ++++++++++++++++
 tb/tb_i2s_trnmtr_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared state encoding and word-width constant for the I2S transmitter
// controller and its helpers.
package i2s_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT,
    DRAIN
  } state_e;

endpackage

// File: rtl/i2s_sck_gen.sv
// SCK divider: toggles sck every CLK_DIV clk cycles while running and flags
// the cycle that ends with a 1->0 sck transition.
module i2s_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic n_rst_i,
  input  logic run_i,
  output logic sck_o,
  output logic fall_tick_o
);

  localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

  logic [7:0] div_q, div_d;
  logic       sck_q, sck_d;
  logic       term;

  assign term = (div_q == TERM);

  // Stopped divider parks at zero so a restart always begins a full half-period.
  always_comb begin
    div_d = div_q;
    sck_d = sck_q;
    if (!run_i) begin
      div_d = '0;
      sck_d = 1'b0;
    end else if (term) begin
      div_d = '0;
      sck_d = ~sck_q;
    end else begin
      div_d = div_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o       = sck_q;
  assign fall_tick_o = run_i & term & sck_q;

endmodule

// File: rtl/i2s_trnmtr_ctrl.sv
// I2S transmitter controller: frame sequencing, one-pair input buffer and
// load/shift strobes for the serialiser. UNDERRUN_REPEAT_EN repeats the last pair on underrun.
module i2s_trnmtr_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int WORD_W  = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              enable,
  input  logic [WORD_W-1:0] sample_l,
  input  logic [WORD_W-1:0] sample_r,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic [WORD_W-1:0] tx_word,
  output logic              load,
  output logic              shift,
  output logic              sck,
  output logic              ws,
  output logic              underrun
);

  import i2s_pkg::*;

  state_e            state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic              ws_q, ws_d;
  logic              load_q, load_d;
  logic              shift_q, shift_d;
  logic              underrun_q, underrun_d;
  logic [WORD_W-1:0] tx_word_q, tx_word_d;
  logic [WORD_W-1:0] hold_r_q, hold_r_d;
  logic [WORD_W-1:0] buf_l_q, buf_l_d;
  logic [WORD_W-1:0] buf_r_q, buf_r_d;
  logic              buf_full_q, buf_full_d;
  logic [WORD_W-1:0] sub_l, sub_r;
  logic              run, fall_tick, accept, left_load, right_load;

  assign run        = (state_q != IDLE);
  assign accept     = sample_valid & ~buf_full_q;
  assign left_load  = fall_tick & (state_q == LEFT)  & (bit_cnt_q == 5'd0);
  assign right_load = fall_tick & (state_q == RIGHT) & (bit_cnt_q == 5'd0);

  i2s_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk_i      (clk),
    .n_rst_i    (n_rst),
    .run_i      (run),
    .sck_o      (sck),
    .fall_tick_o(fall_tick)
  );

`ifdef UNDERRUN_REPEAT_EN
  logic [WORD_W-1:0] last_l_q;

  // hold_r_q already carries the right word of the last pair sent.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_l_q <= '0;
    end else if (left_load) begin
      last_l_q <= tx_word_d;
    end
  end

  assign sub_l = last_l_q;
  assign sub_r = hold_r_q;
`else
  assign sub_l = '0;
  assign sub_r = '0;
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    ws_d       = ws_q;
    load_d     = 1'b0;
    shift_d    = 1'b0;
    underrun_d = 1'b0;
    tx_word_d  = tx_word_q;
    hold_r_d   = hold_r_q;
    buf_full_d = buf_full_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;

    case (state_q)
      IDLE:    if (enable) state_d = LEFT;
      LEFT:    if (fall_tick && bit_cnt_q == 5'd31) state_d = RIGHT;
      RIGHT:   if (fall_tick && bit_cnt_q == 5'd31) state_d = enable ? LEFT : DRAIN;
      DRAIN:   if (fall_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fall_tick) begin
      bit_cnt_d = bit_cnt_q + 5'd1;
      if (state_q == LEFT || state_q == RIGHT) begin
        load_d  = (bit_cnt_q == 5'd0);
        shift_d = (bit_cnt_q != 5'd0);
        if (bit_cnt_q == 5'd31) ws_d = ~ws_q;
      end
    end

    if (state_d == IDLE) begin
      bit_cnt_d = 5'd0;
      ws_d      = 1'b0;
    end

    // Left load consumes the buffered pair; the right half waits in hold_r.
    if (left_load) begin
      buf_full_d = 1'b0;
      if (buf_full_q) begin
        tx_word_d = buf_l_q;
        hold_r_d  = buf_r_q;
      end else begin
        tx_word_d  = sub_l;
        hold_r_d   = sub_r;
        underrun_d = 1'b1;
      end
    end else if (right_load) begin
      tx_word_d = hold_r_q;
    end

    if (accept) begin
      buf_full_d = 1'b1;
      buf_l_d    = sample_l;
      buf_r_d    = sample_r;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      ws_q       <= 1'b0;
      load_q     <= 1'b0;
      shift_q    <= 1'b0;
      underrun_q <= 1'b0;
      tx_word_q  <= '0;
      hold_r_q   <= '0;
      buf_full_q <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      ws_q       <= ws_d;
      load_q     <= load_d;
      shift_q    <= shift_d;
      underrun_q <= underrun_d;
      tx_word_q  <= tx_word_d;
      hold_r_q   <= hold_r_d;
      buf_full_q <= buf_full_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
    end
  end

  assign sample_ready = ~buf_full_q;
  assign tx_word      = tx_word_q;
  assign load         = load_q;
  assign shift        = shift_q;
  assign ws           = ws_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_trnmtr_ctrl.sv
// Self-checking bench for i2s_trnmtr_ctrl: scoreboarded frame stream on a
// CLK_DIV=4 instance plus divider checks on CLK_DIV=2 and CLK_DIV=7 instances.
module tb_i2s_trnmtr_ctrl;

  localparam int DIV = 4;
  localparam int NV  = 11;

  typedef struct packed {
    logic [31:0] l;
    logic [31:0] r;
  } pair_t;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    bit          skip;
    int          expUr;
  } vec_t;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic [31:0] sample_l = '0;
  logic [31:0] sample_r = '0;
  logic        sample_ready, load, shift, sck, ws, underrun;
  logic [31:0] tx_word;

  logic        enDiv = 1'b0;
  logic        divSck [2];
  logic        divLoad [2];
  logic        divShift [2];
  logic        divWs [2];
  logic        divUr [2];
  logic        divReady [2];
  logic [31:0] divTx [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  i2s_trnmtr_ctrl #(.CLK_DIV(DIV)) dut (
    .clk(clk), .n_rst(n_rst), .enable(enable),
    .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .tx_word(tx_word), .load(load), .shift(shift),
    .sck(sck), .ws(ws), .underrun(underrun)
  );

  i2s_trnmtr_ctrl #(.CLK_DIV(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .enable(enDiv),
    .sample_l(32'h0), .sample_r(32'h0), .sample_valid(1'b0),
    .sample_ready(divReady[0]), .tx_word(divTx[0]), .load(divLoad[0]), .shift(divShift[0]),
    .sck(divSck[0]), .ws(divWs[0]), .underrun(divUr[0])
  );

  i2s_trnmtr_ctrl #(.CLK_DIV(7)) dut7 (
    .clk(clk), .n_rst(n_rst), .enable(enDiv),
    .sample_l(32'h0), .sample_r(32'h0), .sample_valid(1'b0),
    .sample_ready(divReady[1]), .tx_word(divTx[1]), .load(divLoad[1]), .shift(divShift[1]),
    .sck(divSck[1]), .ws(divWs[1]), .underrun(divUr[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: accepted pairs queue up; every load pops and compares.
  bit          monOn = 1'b0;
  bit          accPend = 1'b0;
  bit          started = 1'b0;
  bit          chan = 1'b0;
  pair_t       sbq[$];
  pair_t       accPair = '0;
  pair_t       expPair = '0;
  pair_t       lastPair = '0;
  logic [31:0] pendR = '0, curExp = '0, sr = '0, rx = '0;
  int          shiftCnt = 0, leftLoads = 0, rightLoads = 0, wordsDone = 0, urCount = 0;

  always @(negedge clk) begin
    if (monOn) begin
      if (underrun) urCount++;
      if (load) begin
        checkOutput("load_shift_excl", 32'(shift), 32'd0);
        if (started) checkOutput("shifts_between_loads", 32'(shiftCnt), 32'd31);
        started = 1'b1;
        checkOutput("ws_at_load", 32'(ws), 32'(chan));
        if (!chan) begin
          if (sbq.size() == 0) begin
`ifdef UNDERRUN_REPEAT_EN
            expPair = lastPair;
`else
            expPair = '0;
`endif
            checkOutput("underrun_at_load", 32'(underrun), 32'd1);
          end else begin
            expPair = sbq.pop_front();
            checkOutput("underrun_at_load", 32'(underrun), 32'd0);
          end
          checkOutput("tx_word_left", tx_word, expPair.l);
          curExp   = expPair.l;
          pendR    = expPair.r;
          lastPair = expPair;
          leftLoads++;
        end else begin
          checkOutput("tx_word_right", tx_word, pendR);
          curExp = pendR;
          rightLoads++;
        end
        sr       = tx_word;
        rx       = {31'b0, sr[31]};
        shiftCnt = 0;
        chan     = ~chan;
      end else begin
        checkOutput("underrun_no_load", 32'(underrun), 32'd0);
      end
      if (shift) begin
        shiftCnt++;
        sr = sr << 1;
        rx = {rx[30:0], sr[31]};
        if (shiftCnt == 31) begin
          checkOutput("serial_word", rx, curExp);
          checkOutput("ws_lead", 32'(ws), 32'(chan));
          wordsDone++;
        end
      end
    end
    if (accPend) begin
      sbq.push_back(accPair);
      accPend = 1'b0;
    end
  end

  // Divider instances run starved: sck period and strobes per frame.
  bit divOn = 1'b0;
  int cyc = 0;
  int divPer [2] = '{4, 14};
  int lastRise [2] = '{-1, -1};
  int strobes [2] = '{0, 0};
  bit seenLoad [2] = '{1'b0, 1'b0};
  bit prevSck [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    cyc++;
    if (divOn) begin
      for (int k = 0; k < 2; k++) begin
        if (divSck[k] && !prevSck[k]) begin
          if (lastRise[k] >= 0)
            checkOutput(k == 0 ? "sck_period_div2" : "sck_period_div7",
                        32'(cyc - lastRise[k]), 32'(divPer[k]));
          lastRise[k] = cyc;
        end
        prevSck[k] = divSck[k];
        if (divLoad[k] && !divWs[k]) begin
          if (seenLoad[k]) checkOutput("strobes_per_frame", 32'(strobes[k]), 32'd64);
          checkOutput("div_underrun", 32'(divUr[k]), 32'd1);
          checkOutput("div_tx_zero", divTx[k], 32'd0);
          checkOutput("div_ready", 32'(divReady[k]), 32'd1);
          seenLoad[k] = 1'b1;
          strobes[k]  = 0;
        end
        if (divLoad[k] || divShift[k]) strobes[k]++;
      end
    end
  end

  task automatic checkReset(input string tag);
    checkOutput({tag, "_sck"}, 32'(sck), 32'd0);
    checkOutput({tag, "_ws"}, 32'(ws), 32'd0);
    checkOutput({tag, "_load"}, 32'(load), 32'd0);
    checkOutput({tag, "_shift"}, 32'(shift), 32'd0);
    checkOutput({tag, "_underrun"}, 32'(underrun), 32'd0);
    checkOutput({tag, "_tx_word"}, tx_word, 32'd0);
    checkOutput({tag, "_ready"}, 32'(sample_ready), 32'd1);
  endtask

  task automatic offerPair(input logic [31:0] l, input logic [31:0] r);
    int n = 0;
    sample_l     = l;
    sample_r     = r;
    sample_valid = 1'b1;
    while (!sample_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_for_offer", 32'(sample_ready), 32'd1);
    if (sample_ready) begin
      @(posedge clk);
      accPair = {l, r};
      accPend = 1'b1;
      @(negedge clk);
    end
    sample_valid = 1'b0;
  endtask

  // A skipped frame lets the buffered pair go out, then starves the next frame.
  task automatic applyStimulus(input vec_t v);
    int n = 0;
    int target;
    if (v.skip) begin
      #1;
      target = leftLoads + 2;
      while (leftLoads < target && n < 4000) begin
        @(negedge clk);
        #1;
        n++;
      end
      checkOutput("skip_wait", 32'(leftLoads), 32'(target));
    end else begin
      offerPair(v.l, v.r);
    end
  endtask

  vec_t vecs [NV];

  initial begin
    int lat, n, target, l0, r0;
    bit busy;

    vecs[0]  = '{32'h1111_0001, 32'h2222_0001, 1'b0, 0};
    vecs[1]  = '{32'h1111_0002, 32'h2222_0002, 1'b0, 0};
    vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 0};
    vecs[3]  = '{32'h8000_0001, 32'h7FFF_FFFE, 1'b0, 0};
    vecs[4]  = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 0};
    vecs[5]  = '{32'h0123_4567, 32'h89AB_CDEF, 1'b0, 0};
    vecs[6]  = '{32'h5555_AAAA, 32'hAAAA_5555, 1'b0, 0};
    vecs[7]  = '{32'h0F0F_F0F0, 32'hF0F0_0F0F, 1'b0, 0};
    vecs[8]  = '{32'h0, 32'h0, 1'b1, 1};
    vecs[9]  = '{32'h1357_9BDF, 32'h2468_ACE0, 1'b0, 1};
    vecs[10] = '{32'h3C3C_C3C3, 32'hC3C3_3C3C, 1'b0, 1};

    repeat (3) @(negedge clk);
    checkReset("por");
    n_rst = 1'b1;
    @(negedge clk);
    enDiv = 1'b1;
    divOn = 1'b1;
    monOn = 1'b1;

    offerPair(32'hA5A5_0001, 32'h5A5A_0002);

    // Enable is sampled on the next posedge; the first load is registered
    // 2*DIV edges later, i.e. on the (2*DIV+1)-th edge counted here.
    enable = 1'b1;
    lat = 0;
    while (!load && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    checkOutput("first_load_latency", 32'(lat), 32'(2 * DIV + 1));

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput("underrun_count", 32'(urCount), 32'(vecs[i].expUr));
    end

    // Drop enable part-way through the left word of the last pair.
    target = leftLoads + 1;
    n = 0;
    while ((leftLoads < target || shiftCnt < 10) && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("stop_point_shifts", 32'(shiftCnt), 32'd10);
    enable = 1'b0;
    l0 = leftLoads;
    r0 = rightLoads;
    repeat (700) @(negedge clk);
    #1;
    checkOutput("stop_left_loads", 32'(leftLoads), 32'(l0));
    checkOutput("stop_right_loads", 32'(rightLoads), 32'(r0 + 1));
    checkOutput("stop_words_complete", 32'(wordsDone), 32'(leftLoads + rightLoads));
    checkOutput("stop_sck", 32'(sck), 32'd0);
    checkOutput("stop_ws", 32'(ws), 32'd0);
    busy = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (sck || load || shift || ws) busy = 1'b1;
    end
    checkOutput("idle_quiet", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a frame.
    monOn = 1'b0;
    divOn = 1'b0;
    enable = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    checkReset("midframe");
    enable = 1'b0;
    repeat (2) @(negedge clk);
    checkReset("held");
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    failures++;
    $display("[TB] FAIL watchdog: got no finish expected finish within 60000 cycles");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
